// File: rtl/ram512_stream_loader_if.sv
// Byte-stream handshake plus RAM write bus for the 512x16 stream loader.
// master = stream source / RAM side, slave = loader.
interface ram512_stream_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [DATA_W/2-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [DATA_W-1:0]   mem_in;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_load;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  mem_in,
        input  mem_address,
        input  mem_load
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output mem_in,
        output mem_address,
        output mem_load
    );
endinterface

// File: rtl/ram512_stream_loader.sv
// Assembles high-byte-first byte pairs into words and writes them to
// consecutive RAM addresses from a programmable base.
module ram512_stream_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    ram512_stream_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [DATA_W/2-1:0]   hi_byte;
    logic [ADDR_W:0]       remaining;
    logic                  s_ready;
    logic                  hs;

    assign s_ready      = (state == HI) || (state == LO);
    assign hs           = bus.s_valid && s_ready;
    assign bus.s_ready  = s_ready;
    assign bus.mem_load = (state == WRITE);
    assign busy         = (state == HI) || (state == LO) || (state == WRITE);
    assign done         = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (word_count == '0) ? DONE : HI;
            end
            HI:    if (hs) state_n = LO;
            LO:    if (hs) state_n = WRITE;
            WRITE: begin
                if (remaining == (ADDR_W+1)'(1))
                    state_n = DONE;
                else
                    state_n = HI;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Datapath registers; reset drops any half-assembled word.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte         <= '0;
            remaining       <= '0;
            words_written   <= '0;
            bus.mem_in      <= '0;
            bus.mem_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        words_written <= '0;
                        if (word_count != '0) begin
                            bus.mem_address <= base_addr;
                            remaining       <= word_count;
                        end
                    end
                end
                HI: begin
                    if (hs) hi_byte <= bus.s_data;
                end
                LO: begin
                    if (hs) bus.mem_in <= {hi_byte, bus.s_data};
                end
                WRITE: begin
                    bus.mem_address <= bus.mem_address + 1'b1;
                    words_written   <= words_written + 1'b1;
                    remaining       <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram512_stream_loader.sv
// Directed bench for ram512_stream_loader with a behavioural 512x16 RAM
// and pulse counters on mem_load / done.
module tb_ram512_stream_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] base_addr;
    logic [9:0] word_count;
    logic       busy;
    logic       done;
    logic [9:0] words_written;

    int vectors;
    int miscompares;
    int cyc;
    int loads;
    int dones;
    int load_cyc[$];
    logic [15:0] ram [512];

    ram512_stream_loader_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    ram512_stream_loader #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .bus           (bus.slave),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_load) begin
            ram[bus.mem_address] <= bus.mem_in;
            loads <= loads + 1;
            load_cyc.push_back(cyc + 1);
        end
        if (done) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] b, input logic [9:0] n);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.s_data = b;
        bus.s_valid = 1'b1;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("hs_timeout", 32'(n), 0);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("done_timeout", 32'(n), 0);
        @(negedge clk);
    endtask

    initial begin
        int t0, l0, d0, bad;
        logic [15:0] w;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        loads = 0;
        dones = 0;
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_load", bus.mem_load, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_in", bus.mem_in, 0);
        chk("rst_ww", words_written, 0);

        // 1: basic transfer, s_valid held high
        load_cyc.delete();
        l0 = loads; d0 = dones;
        do_start(9'h010, 10'd2);
        t0 = cyc;
        chk("s1_busy", busy, 1);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'hAB, 0);
        send(8'hCD, 0);
        wait_done(50);
        chk("s1_ram10", ram[9'h010], 16'h1234);
        chk("s1_ram11", ram[9'h011], 16'hABCD);
        chk("s1_loads", loads - l0, 2);
        chk("s1_dones", dones - d0, 1);
        chk("s1_ww", words_written, 2);
        chk("s1_busy_end", busy, 0);
        chk("s1_addr", bus.mem_address, 9'h012);
        chk("s1_ld0", (load_cyc.size() > 0) ? load_cyc[0] - t0 : -1, 3);
        chk("s1_ld1", (load_cyc.size() > 1) ? load_cyc[1] - t0 : -1, 6);

        // 2: address wrap
        do_start(9'h1FF, 10'd2);
        send(8'hDE, 0);
        send(8'hAD, 0);
        send(8'hBE, 0);
        send(8'hEF, 0);
        wait_done(50);
        chk("s2_ram1ff", ram[9'h1FF], 16'hDEAD);
        chk("s2_ram000", ram[9'h000], 16'hBEEF);
        chk("s2_addr", bus.mem_address, 9'h001);

        // 3: stalled stream
        ram[9'h010] = 16'h0000;
        ram[9'h011] = 16'h0000;
        l0 = loads; d0 = dones;
        do_start(9'h010, 10'd2);
        repeat (4) @(negedge clk);
        chk("s3_hi_ready", bus.s_ready, 1);
        send(8'h12, 0);
        repeat (4) @(negedge clk);
        chk("s3_lo_ready", bus.s_ready, 1);
        chk("s3_noload", loads - l0, 0);
        send(8'h34, 0);
        send(8'hAB, 4);
        send(8'hCD, 4);
        wait_done(100);
        chk("s3_ram10", ram[9'h010], 16'h1234);
        chk("s3_ram11", ram[9'h011], 16'hABCD);
        chk("s3_loads", loads - l0, 2);
        chk("s3_dones", dones - d0, 1);

        // 4a: zero count
        l0 = loads; d0 = dones;
        do_start(9'h040, 10'd0);
        chk("s4_done", done, 1);
        chk("s4_busy", busy, 0);
        chk("s4_ww", words_written, 0);
        @(negedge clk);
        chk("s4_done_off", done, 0);
        chk("s4_noload", loads - l0, 0);
        chk("s4_dones", dones - d0, 1);

        // 4b: start while busy is ignored
        l0 = loads;
        do_start(9'h030, 10'd3);
        send(8'h11, 0);
        start = 1'b1;
        base_addr = 9'h100;
        word_count = 10'd5;
        send(8'h22, 0);
        send(8'h33, 0);
        start = 1'b0;
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        wait_done(50);
        chk("s4_ram30", ram[9'h030], 16'h1122);
        chk("s4_ram31", ram[9'h031], 16'h3344);
        chk("s4_ram32", ram[9'h032], 16'h5566);
        chk("s4_ram100", ram[9'h100], 16'h0000);
        chk("s4_addr", bus.mem_address, 9'h033);
        chk("s4_loads", loads - l0, 3);

        // 5: reset mid-transfer
        l0 = loads;
        do_start(9'h020, 10'd2);
        send(8'h55, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_ready", bus.s_ready, 0);
        chk("s5_ww", words_written, 0);
        chk("s5_noload", loads - l0, 0);
        chk("s5_ram20", ram[9'h020], 16'h0000);
        do_start(9'h020, 10'd1);
        send(8'h9A, 0);
        send(8'hBC, 0);
        wait_done(50);
        chk("s5_ram20_new", ram[9'h020], 16'h9ABC);
        chk("s5_ww_new", words_written, 1);

        // 6: full 512-word fill
        l0 = loads; d0 = dones;
        do_start(9'h000, 10'd512);
        for (int i = 0; i < 512; i++) begin
            w = 16'(i);
            send(w[15:8], 0);
            send(w[7:0], 0);
        end
        wait_done(50);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (ram[i] !== 16'(i)) bad++;
        chk("s6_badwords", bad, 0);
        chk("s6_loads", loads - l0, 512);
        chk("s6_dones", dones - d0, 1);
        chk("s6_ww", words_written, 512);
        chk("s6_addr", bus.mem_address, 9'h000);
        chk("s6_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
